// File: rtl/imem_loader_pkg.sv
// Shared loader types and constants.
// Holds the FSM encoding, default region parameters and the count saturation helper.
package loader_pkg;

  localparam int unsigned DEF_LANE_B_BASE = 512;
  localparam int unsigned DEF_MAX_WORDS   = 512;
  localparam int unsigned BYTES_PER_WORD  = 4;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RECV  = 3'd1,
    S_WRITE = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Clamp a requested word count to the per-lane image limit.
  function automatic logic [9:0] sat_count(
    input logic [9:0]  n,
    input int unsigned max
  );
    if (32'(n) > max) return 10'(max);
    return n;
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Loader bus: load request, byte stream in, memory write port and status out.
// master = host/driver side, slave = loader side.
interface imem_loader_if;
  logic        start;
  logic        lane;
  logic [9:0]  word_count;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        busy;
  logic        cpu_hold;
  logic        done;
  logic        chk_err;

  modport master (
    output start, lane, word_count, in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata,
    input  busy, cpu_hold, done, chk_err
  );

  modport slave (
    input  start, lane, word_count, in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata,
    output busy, cpu_hold, done, chk_err
  );
endinterface

// File: rtl/imem_loader_packer.sv
// byte_packer: gathers 4 stream bytes little-endian into a word.
// Ports: clr_i, byte_valid_i, byte_i in; word_o, word_valid_o (4th byte accepted) out.
module byte_packer
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_valid_o
);

  logic [1:0]  cnt_q;
  logic [23:0] acc_q;

  // Shift right so the first byte ends up in bits 7:0; the 4th byte
  // is merged combinationally so the word is usable on its accept edge.
  assign word_o       = {byte_i, acc_q};
  assign word_valid_o = byte_valid_i &&
                        (cnt_q == 2'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      acc_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
      acc_q <= '0;
    end else if (byte_valid_i) begin
      cnt_q <= cnt_q + 2'd1;
      acc_q <= {byte_i, acc_q[23:8]};
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: streams an image into lane A/B, then checks an XOR checksum.
// Ports: clk, rst (async high), bus (slave modport: request, stream, mem write, status).
module imem_loader
  import loader_pkg::*;
#(
  parameter int unsigned LANE_B_BASE = DEF_LANE_B_BASE,
  parameter int unsigned MAX_WORDS   = DEF_MAX_WORDS
) (
  input logic          clk,
  input logic          rst,
  imem_loader_if.slave bus
);

  state_t      state_q;
  logic        lane_q;
  logic [9:0]  cnt_q;
  logic [9:0]  cnt_d;
  logic [9:0]  idx_q;
  logic [31:0] csum_q;
  logic        in_ready_q;
  logic        mem_we_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic        busy_q;
  logic        done_q;
  logic        chk_err_q;

  logic        start_ok;
  logic        byte_ok;
  logic [31:0] word;
  logic        word_valid;
  logic [31:0] base;

  assign start_ok = (state_q == S_IDLE) && bus.start;
  assign byte_ok  = bus.in_valid && in_ready_q;
  assign cnt_d    = sat_count(bus.word_count, MAX_WORDS);
  assign base     = lane_q ? 32'(LANE_B_BASE) : 32'd0;

  byte_packer u_packer (
    .clk          (clk),
    .rst          (rst),
    .clr_i        (start_ok),
    .byte_valid_i (byte_ok),
    .byte_i       (bus.in_data),
    .word_o       (word),
    .word_valid_o (word_valid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      lane_q      <= 1'b0;
      cnt_q       <= '0;
      idx_q       <= '0;
      csum_q      <= '0;
      in_ready_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      chk_err_q   <= 1'b0;
    end else begin
      mem_we_q <= 1'b0;
      done_q   <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            lane_q     <= bus.lane;
            cnt_q      <= cnt_d;
            idx_q      <= '0;
            csum_q     <= '0;
            chk_err_q  <= 1'b0;
            busy_q     <= 1'b1;
            in_ready_q <= 1'b1;
            state_q    <= (cnt_d == '0) ? S_CHECK : S_RECV;
          end
        end
        S_RECV: begin
          if (word_valid) begin
            in_ready_q  <= 1'b0;
            mem_we_q    <= 1'b1;
            mem_addr_q  <= base + 32'(idx_q);
            mem_wdata_q <= word;
            state_q     <= S_WRITE;
          end
        end
        S_WRITE: begin
          csum_q     <= csum_q ^ mem_wdata_q;
          idx_q      <= idx_q + 10'd1;
          in_ready_q <= 1'b1;
          state_q    <= (idx_q + 10'd1 == cnt_q) ? S_CHECK : S_RECV;
        end
        S_CHECK: begin
          if (word_valid) begin
            chk_err_q  <= (word != csum_q);
            in_ready_q <= 1'b0;
            done_q     <= 1'b1;
            state_q    <= S_DONE;
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.busy      = busy_q;
  assign bus.cpu_hold  = busy_q;
  assign bus.done      = done_q;
  assign bus.chk_err   = chk_err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader.
// Table of loads plus reset, saturation and gap/start-spam sequences.
module tb_imem_loader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  imem_loader_if bus ();

  imem_loader dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic        lane;
    logic [9:0]  cnt;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [31:0] csum;
    logic        err;
    logic        gaps;
  } vec_t;

  wr_t  exp_q[$];
  int   nchk = 0;
  int   nfail = 0;
  int   nwr = 0;
  int   cyc = 0;
  int   last_wr_cyc = -1;
  logic [31:0] last_addr = '0;
  logic spacing_on = 1'b0;
  int   spacing_bad = 0;
  logic in_load = 1'b0;
  int   busy_drop = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Write monitor / scoreboard
  always @(negedge clk) begin
    if (!rst && bus.mem_we === 1'b1) begin
      nwr++;
      if (spacing_on && last_wr_cyc >= 0 && cyc - last_wr_cyc != 5)
        spacing_bad++;
      last_wr_cyc = cyc;
      last_addr = bus.mem_addr;
      if (exp_q.size() == 0) begin
        nchk++;
        nfail++;
        $display("FAIL extra_write: got addr %h data %h expected none",
                 bus.mem_addr, bus.mem_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", bus.mem_addr, e.addr);
        chk("wr_data", bus.mem_wdata, e.data);
      end
    end
    if (in_load && bus.busy !== 1'b1) busy_drop++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic ln, input logic [9:0] cnt);
    bus.start = 1'b1;
    bus.lane = ln;
    bus.word_count = cnt;
    tick();
    bus.start = 1'b0;
    in_load = 1'b1;
  endtask

  // Sends one byte; in gap mode inserts random idle cycles and spams start.
  task automatic send_byte(input logic [7:0] b, input logic gaps);
    int g;
    if (gaps) begin
      g = int'($urandom_range(0, 3));
      for (int k = 0; k < g; k++) begin
        bus.in_valid = 1'b0;
        bus.start = $urandom_range(0, 1) == 1;
        bus.lane = $urandom_range(0, 1) == 1;
        bus.word_count = 10'($urandom_range(0, 1023));
        tick();
      end
      bus.start = 1'b0;
    end
    bus.in_valid = 1'b1;
    bus.in_data = b;
    g = 0;
    while (bus.in_ready !== 1'b1 && g < 50) begin
      tick();
      g++;
    end
    if (g >= 50) chk("in_ready_timeout", 32'(g), 32'd0);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input logic gaps);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gaps);
  endtask

  task automatic wait_done(input logic exp_err, input string tag);
    int g = 0;
    while (bus.done !== 1'b1 && g < 100) begin
      tick();
      g++;
    end
    chk({tag, "_done"}, {31'd0, bus.done}, 32'd1);
    chk({tag, "_chk_err"}, {31'd0, bus.chk_err}, {31'd0, exp_err});
    in_load = 1'b0;
    tick();
    chk({tag, "_done_pulse"}, {31'd0, bus.done}, 32'd0);
    chk({tag, "_busy_off"}, {30'd0, bus.busy, bus.cpu_hold}, 32'd0);
    chk({tag, "_chk_err_hold"}, {31'd0, bus.chk_err}, {31'd0, exp_err});
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_flags"},
        {26'd0, bus.in_ready, bus.mem_we, bus.busy, bus.cpu_hold,
         bus.done, bus.chk_err}, 32'd0);
    chk({tag, "_addr"}, bus.mem_addr, 32'd0);
    chk({tag, "_wdata"}, bus.mem_wdata, 32'd0);
  endtask

  vec_t vecs[6];

  initial begin
    logic        prev_err;
    logic [31:0] w;
    logic [31:0] cs;
    logic [31:0] base;
    int          wr0;

    vecs[0] = '{1'b0, 10'd2, 32'h0000_0013, 32'h0010_0093,
                32'h0010_0080, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 10'd1, 32'hDEAD_BEEF, 32'h0,
                32'hDEAD_BEEF, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 10'd1, 32'h0000_0001, 32'h0,
                32'h0000_0000, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 10'd0, 32'h0, 32'h0,
                32'h0000_0000, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 10'd2, 32'hCAFE_F00D, 32'h1234_5678,
                32'hD8CA_A675, 1'b0, 1'b1};
    vecs[5] = '{1'b0, 10'd2, 32'h0000_0013, 32'h0010_0093,
                32'h0010_0080, 1'b0, 1'b1};

    bus.start = 1'b0;
    bus.lane = 1'b0;
    bus.word_count = '0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;

    tick();
    tick();
    chk_reset_outs("reset");
    rst = 1'b0;
    tick();
    chk_reset_outs("idle");

    // Mid-load reset: one word written, then everything cleared
    wr0 = nwr;
    exp_q.push_back('{32'd0, 32'h4433_2211});
    do_start(1'b0, 10'd3);
    send_word(32'h4433_2211, 1'b0);
    send_byte(8'h55, 1'b0);
    send_byte(8'h66, 1'b0);
    in_load = 1'b0;
    rst = 1'b1;
    #1;
    chk_reset_outs("midrst");
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk_reset_outs("midrst_after");
    chk("midrst_writes", 32'(nwr - wr0), 32'd1);

    // Table-driven loads
    prev_err = 1'b0;
    foreach (vecs[v]) begin
      chk("sticky_err", {31'd0, bus.chk_err}, {31'd0, prev_err});
      wr0 = nwr;
      base = vecs[v].lane ? 32'd512 : 32'd0;
      if (vecs[v].cnt > 0) exp_q.push_back('{base, vecs[v].w0});
      if (vecs[v].cnt > 1) exp_q.push_back('{base + 1, vecs[v].w1});
      do_start(vecs[v].lane, vecs[v].cnt);
      chk("start_state",
          {29'd0, bus.busy, bus.cpu_hold, bus.chk_err}, 32'd6);
      if (vecs[v].cnt > 0) send_word(vecs[v].w0, vecs[v].gaps);
      if (vecs[v].cnt > 1) send_word(vecs[v].w1, vecs[v].gaps);
      send_word(vecs[v].csum, vecs[v].gaps);
      wait_done(vecs[v].err, $sformatf("vec%0d", v));
      chk("vec_writes", 32'(nwr - wr0), 32'(vecs[v].cnt));
      chk("vec_sb_empty", 32'(exp_q.size()), 32'd0);
      prev_err = vecs[v].err;
      for (int i = 0; i < 3; i++) tick();
    end
    chk("busy_continuous", 32'(busy_drop), 32'd0);

    // Saturation: 1000 requested, 512 written at full stream rate
    wr0 = nwr;
    cs = '0;
    do_start(1'b0, 10'd1000);
    spacing_on = 1'b1;
    last_wr_cyc = -1;
    for (int i = 0; i < 512; i++) begin
      w = $urandom;
      cs ^= w;
      exp_q.push_back('{32'(i), w});
      send_word(w, 1'b0);
    end
    send_word(cs, 1'b0);
    wait_done(1'b0, "sat");
    spacing_on = 1'b0;
    chk("sat_writes", 32'(nwr - wr0), 32'd512);
    chk("sat_last_addr", last_addr, 32'd511);
    chk("sat_spacing", 32'(spacing_bad), 32'd0);
    chk("sat_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
